// File: rtl/fft_sdf_scheduler.sv
// fft_sdf_scheduler: frame-aware sequencer for the radix-2 SDF FFT stage chain.
// Define FFT_SCHED_FRAME_CNT_EN to build the completed-frame counter behind frame_count.
module fft_sdf_scheduler #(
    parameter int NFFT       = 64,
    parameter int PIPE_EXTRA = 3,
    localparam int L         = $clog2(NFFT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    output logic         in_ready,
    output logic [L-1:0] stage_start,
    output logic [L-1:0] stage_sel,
    output logic         out_valid,
    output logic [L-1:0] out_index,
    output logic         frame_done,
    output logic         busy,
    output logic [15:0]  frame_count
);
    // state | meaning
    // IDLE  | waiting for run; stage counters held at 0
    // RUN   | accepting one sample per cycle, whole frames only
    // DRAIN | input stopped, flushing the pipeline for T_OUT cycles
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int T_OUT = NFFT - 1 + L * PIPE_EXTRA;
    localparam int DW    = $clog2(T_OUT);

    state_t         state;
    logic [L-1:0]   in_cnt;
    logic [DW-1:0]  drain_cnt;
    logic [T_OUT-1:0] dly;
    logic [L-1:0]   oc;

    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_cnt    <= '0;
                    drain_cnt <= '0;
                    if (run) state <= RUN;
                end
                RUN: begin
                    in_cnt <= in_cnt + 1'b1;
                    if (in_cnt == L'(NFFT - 1) && !run) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt == DW'(T_OUT - 1)) state <= IDLE;
                    else drain_cnt <= drain_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // dly[k] is in_ready delayed by k+1 cycles; it is never flushed by IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dly <= '0;
        else      dly <= {dly[T_OUT-2:0], in_ready};
    end

    for (genvar s = 1; s <= L; s++) begin : g_stage
        localparam int TS = NFFT - (NFFT >> (s - 1)) + (s - 1) * PIPE_EXTRA;
        logic         v;
        logic         v_prev;
        logic [L-1:0] cnt;

        if (TS == 0) begin : g_first
            assign v = in_ready;
        end else begin : g_later
            assign v = dly[TS-1];
        end
        assign v_prev = dly[TS];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                cnt <= '0;
            else if (state == IDLE)  cnt <= '0;
            else if (v)              cnt <= cnt + 1'b1;
        end

        assign stage_sel[s-1]   = v & cnt[L-s];
        assign stage_start[s-1] = v & ~v_prev;
    end

    assign out_valid = dly[T_OUT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           oc <= '0;
        else if (out_valid) oc <= oc + 1'b1;
    end

    always_comb begin
        out_index = '0;
        for (int i = 0; i < L; i++) out_index[i] = oc[L-1-i];
    end

    assign frame_done = out_valid & (oc == L'(NFFT - 1));

`ifdef FFT_SCHED_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            frame_cnt_q <= '0;
        else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_fft_sdf_scheduler.sv
// Bench for fft_sdf_scheduler: fixed single-frame vector table, hand sequences and
// a random run pattern checked cycle by cycle against a frame-level reference model.
module tb_fft_sdf_scheduler;
    localparam int NFFT  = 64;
    localparam int L     = 6;
    localparam int PE    = 3;
    localparam int T_OUT = 81;
    localparam int MAXC  = 8000;

    typedef enum int {SIG_IR, SIG_START, SIG_SEL0, SIG_SEL5, SIG_OV, SIG_IDX, SIG_FD, SIG_BUSY} sig_t;
    typedef struct {
        int    off;
        sig_t  sig;
        int    exp;
        string name;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         run;
    logic         in_ready;
    logic [L-1:0] stage_start;
    logic [L-1:0] stage_sel;
    logic         out_valid;
    logic [L-1:0] out_index;
    logic         frame_done;
    logic         busy;
    logic [15:0]  frame_count;

    fft_sdf_scheduler #(.NFFT(NFFT), .PIPE_EXTRA(PE)) dut (
        .clk(clk), .rst(rst), .run(run), .in_ready(in_ready),
        .stage_start(stage_start), .stage_sel(stage_sel), .out_valid(out_valid),
        .out_index(out_index), .frame_done(frame_done), .busy(busy),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int toff[L];

    // reference model: per-cycle history of accepted samples and their frame position
    bit ir_h[MAXC];
    int pos_h[MAXC];
    bit rst_h[MAXC];
    bit run_h[MAXC];
    bit streaming;
    int start_c, idle_from, zero_before, fc_model;

    bit           t_ir[MAXC], t_busy[MAXC], t_ov[MAXC], t_fd[MAXC];
    logic [L-1:0] t_st[MAXC], t_sel[MAXC], t_idx[MAXC];

    vec_t vecs[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit hist(input int m);
        if (m < 0 || m < zero_before || m >= MAXC) return 1'b0;
        return ir_h[m];
    endfunction

    function automatic int posf(input int m);
        if (m < 0 || m >= MAXC) return 0;
        return pos_h[m];
    endfunction

    function automatic int bitrev(input int p);
        int r;
        r = 0;
        for (int i = 0; i < L; i++) r = r * 2 + ((p >> i) & 1);
        return r;
    endfunction

    task automatic check_cycle();
        logic [21:0]  e, a;
        logic [L-1:0] e_st, e_sel, e_idx;
        bit           e_ir, e_busy, e_ov, e_fd;
        int           n, m, p;
        n = cyc;
        e_st = '0; e_sel = '0; e_idx = '0;
        e_ir = 0; e_busy = 0; e_ov = 0; e_fd = 0;
        if (rst_h[n]) begin
            e_ir   = hist(n);
            e_busy = e_ir || (n < idle_from);
            for (int s = 0; s < L; s++) begin
                m = n - toff[s];
                e_st[s]  = hist(m) && !hist(m - 1);
                e_sel[s] = hist(m) && (((posf(m) >> (L - 1 - s)) & 1) == 1);
            end
            e_ov = hist(n - T_OUT);
            p    = posf(n - T_OUT);
            if (e_ov) begin
                e_idx = L'(bitrev(p));
                e_fd  = (p == NFFT - 1);
            end
        end
        e = {e_ir, e_busy, e_st, e_sel, e_ov, e_idx, e_fd};
        a = {in_ready, busy, stage_start, stage_sel, out_valid, out_index, frame_done};
        cmp("cycle_outputs", 32'(a), 32'(e));
`ifdef FFT_SCHED_FRAME_CNT_EN
        cmp("frame_count", 32'(frame_count), 32'(fc_model));
`else
        cmp("frame_count", 32'(frame_count), 32'(0));
`endif
        if (rst_h[n] && e_fd) fc_model = (fc_model + 1) & 32'hffff;
        t_ir[n] = in_ready; t_busy[n] = busy; t_ov[n] = out_valid; t_fd[n] = frame_done;
        t_st[n] = stage_start; t_sel[n] = stage_sel; t_idx[n] = out_index;
    endtask

    task automatic advance();
        int n;
        n = cyc;
        if (!rst_h[n-1]) begin
            streaming = 0;
        end else if (streaming) begin
            if (pos_h[n-1] == NFFT - 1 && !run_h[n-1]) begin
                streaming = 0;
                idle_from = n + T_OUT;
            end
        end else if (n - 1 >= idle_from && run_h[n-1]) begin
            streaming = 1;
            start_c   = n;
        end
        ir_h[n]  = streaming;
        pos_h[n] = streaming ? (n - start_c) % NFFT : 0;
    endtask

    task automatic step(input bit r);
        run = r;
        run_h[cyc] = r;
        rst_h[cyc] = rst;
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        cyc++;
        advance();
        #1;
    endtask

    task automatic assert_reset_now();
        rst = 1'b0;
        rst_h[cyc] = 1'b0;
        #1;
        cmp("abort_zero", 32'({in_ready, busy, stage_start, stage_sel, out_valid,
                               out_index, frame_done, frame_count}), 32'(0));
        streaming   = 0;
        idle_from   = 0;
        zero_before = cyc + 1;
        fc_model    = 0;
    endtask

    task automatic add(input string name, input int off, input sig_t sig, input int exp);
        vec_t v;
        v.name = name; v.off = off; v.sig = sig; v.exp = exp;
        vecs.push_back(v);
    endtask

    int          c0, c1, s0, k, nz, cnt, first, last;
    logic [31:0] act;
    int          probs[4];
    bit          r;

    initial begin
        toff[0] = 0;
        for (int s = 1; s < L; s++) toff[s] = toff[s-1] + (NFFT >> s) + PE;

        add("ir_before", -1, SIG_IR, 0);     add("ir_off0", 0, SIG_IR, 1);
        add("ir_off63", 63, SIG_IR, 1);      add("ir_off64", 64, SIG_IR, 0);
        add("start_s1", 0, SIG_START, 'h01); add("start_off1", 1, SIG_START, 0);
        add("start_s2", 35, SIG_START, 'h02); add("start_s3", 54, SIG_START, 'h04);
        add("start_s4", 65, SIG_START, 'h08); add("start_s5", 72, SIG_START, 'h10);
        add("start_s6", 77, SIG_START, 'h20);
        add("sel1_off0", 0, SIG_SEL0, 0);    add("sel1_off31", 31, SIG_SEL0, 0);
        add("sel1_off32", 32, SIG_SEL0, 1);  add("sel1_off63", 63, SIG_SEL0, 1);
        add("sel6_off76", 76, SIG_SEL5, 0);  add("sel6_off77", 77, SIG_SEL5, 0);
        add("sel6_off78", 78, SIG_SEL5, 1);  add("sel6_off79", 79, SIG_SEL5, 0);
        add("sel6_off80", 80, SIG_SEL5, 1);
        add("ov_off80", 80, SIG_OV, 0);      add("ov_off81", 81, SIG_OV, 1);
        add("ov_off144", 144, SIG_OV, 1);    add("ov_off145", 145, SIG_OV, 0);
        add("idx0", 81, SIG_IDX, 0);  add("idx1", 82, SIG_IDX, 32); add("idx2", 83, SIG_IDX, 16);
        add("idx3", 84, SIG_IDX, 48); add("idx4", 85, SIG_IDX, 8);  add("idx5", 86, SIG_IDX, 40);
        add("idx6", 87, SIG_IDX, 24); add("idx7", 88, SIG_IDX, 56); add("idx_last", 144, SIG_IDX, 63);
        add("fd_off143", 143, SIG_FD, 0);    add("fd_off144", 144, SIG_FD, 1);
        add("busy_off0", 0, SIG_BUSY, 1);    add("busy_off144", 144, SIG_BUSY, 1);
        add("busy_off145", 145, SIG_BUSY, 0);

        rst = 1'b0; run = 1'b0;
        streaming = 0; start_c = 0; idle_from = 0; zero_before = 0; fc_model = 0;
        repeat (3) step(0);
        rst = 1'b1;

        // idle with run low
        c0 = cyc;
        repeat (100) step(0);
        nz = 0;
        for (int i = c0; i < cyc; i++)
            if (t_ir[i] || t_busy[i] || t_ov[i] || t_fd[i] || t_st[i] != 0 || t_sel[i] != 0)
                nz++;
        cmp("idle_quiet", nz, 0);

        // single frame from a one-cycle run pulse
        c0 = cyc;
        step(1);
        repeat (160) step(0);
        s0 = c0 + 1;
        foreach (vecs[i]) begin
            k = s0 + vecs[i].off;
            case (vecs[i].sig)
                SIG_IR:    act = 32'(t_ir[k]);
                SIG_START: act = 32'(t_st[k]);
                SIG_SEL0:  act = 32'(t_sel[k][0]);
                SIG_SEL5:  act = 32'(t_sel[k][5]);
                SIG_OV:    act = 32'(t_ov[k]);
                SIG_IDX:   act = 32'(t_idx[k]);
                SIG_FD:    act = 32'(t_fd[k]);
                default:   act = 32'(t_busy[k]);
            endcase
            cmp(vecs[i].name, act, vecs[i].exp);
        end
        cnt = 0;
        for (int i = c0; i < cyc; i++) cnt += int'(t_ir[i]);
        cmp("single_ir_len", cnt, 64);

        // three back-to-back frames, run dropped mid third frame
        assert_reset_now();
        step(0); step(0);
        rst = 1'b1;
        c0 = cyc;
        repeat (150) step(1);
        repeat (230) step(0);
        cnt = 0; first = -1; last = -1;
        for (int i = c0; i < cyc; i++)
            if (t_ir[i]) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        cmp("cont_ir_count", cnt, 192);
        cmp("cont_ir_span", last - first + 1, 192);
        cnt = 0;
        for (int i = c0; i < cyc; i++) cnt += int'(t_fd[i]);
        cmp("cont_frame_done", cnt, 3);
`ifdef FFT_SCHED_FRAME_CNT_EN
        cmp("cont_frame_count", 32'(frame_count), 32'(3));
`else
        cmp("cont_frame_count", 32'(frame_count), 32'(0));
`endif

        // abort at offset 100, restart, then run pulse during drain
        c0 = cyc;
        step(1);
        repeat (100) step(0);
        assert_reset_now();
        repeat (3) step(0);
        rst = 1'b1;
        repeat (2) step(0);
        c1 = cyc;
        step(1); step(0); step(0);
        cmp("restart_start0", 32'(t_st[c1+1][0]), 32'(1));
        cmp("restart_ir", 32'(t_ir[c1+1]), 32'(1));
        repeat (97) step(0);
        step(1);
        repeat (130) step(0);
        cnt = 0;
        for (int i = c1 + 65; i < cyc; i++) cnt += int'(t_ir[i]);
        cmp("drain_no_restart", cnt, 0);
        cmp("drain_busy_last", 32'(t_busy[c1+145]), 32'(1));
        cmp("drain_busy_fall", 32'(t_busy[c1+146]), 32'(0));

        // random run patterns with one asynchronous abort
        probs[0] = 90; probs[1] = 3; probs[2] = 50; probs[3] = 10;
        for (int seg = 0; seg < 4; seg++) begin
            for (int j = 0; j < 600; j++) begin
                if (seg == 2 && j == 300) begin
                    assert_reset_now();
                    step(0); step(0);
                    rst = 1'b1;
                end
                r = ($urandom_range(0, 99) < probs[seg]);
                step(r);
            end
        end
        repeat (200) step(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
